// File: rtl/hex_display_arbiter.sv
// Round-robin owner of the two-digit seven-segment display with minimum hold.
// Optional HEXARB_PREEMPT_EN lets requester 0 preempt any other owner.
module hex_display_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 50000000,
    parameter int CNT_W       = 26
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] data,
    output logic [NUM_REQ-1:0]   grant,
    output logic [2:0]           owner,
    output logic                 active,
    output logic [6:0]           hex0,
    output logic [6:0]           hex1
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [6:0]       BLANK = 7'h7F;
    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [2:0]         owner_q, owner_d;
    logic               active_q, active_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [6:0]         hex0_q, hex0_d;
    logic [6:0]         hex1_q, hex1_d;

    logic               win_found;
    logic [2:0]         win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic               own_req;
    logic [7:0]         own_data;
    logic               others_req;
    logic               release_now;

`ifdef HEXARB_PREEMPT_EN
    logic pend_q, pend_d;
    logic preempt;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Scan above the last owner first, then wrap; last owner is checked last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req[i] && (i > int'(owner_q))) begin
                win_found = 1'b1;
                win_idx   = 3'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req[i] && (i <= int'(owner_q))) begin
                win_found = 1'b1;
                win_idx   = 3'(i);
            end
        end
`ifdef HEXARB_PREEMPT_EN
        if (state_q == S_GAP && pend_q && req[0]) begin
            win_found = 1'b1;
            win_idx   = 3'd0;
        end
`endif
    end

    always_comb begin
        win_onehot = '0;
        own_req    = 1'b0;
        own_data   = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_onehot[i] = win_found && (win_idx == 3'(i));
            if (owner_q == 3'(i)) begin
                own_req  = req[i];
                own_data = data[i*8 +: 8];
            end
        end
        others_req = |(req & ~grant_q);
    end

`ifdef HEXARB_PREEMPT_EN
    assign preempt = (owner_q != 3'd0) && req[0];
`endif

    always_comb begin
        release_now = !own_req
                   || ((cnt_q == '0) && others_req);
`ifdef HEXARB_PREEMPT_EN
        release_now = release_now || preempt;
`endif
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        hex0_d   = BLANK;
        hex1_d   = BLANK;
`ifdef HEXARB_PREEMPT_EN
        pend_d   = pend_q;
`endif
        case (state_q)
            S_OWN: begin
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
                if (release_now) begin
                    state_d  = S_GAP;
                    grant_d  = '0;
                    active_d = 1'b0;
`ifdef HEXARB_PREEMPT_EN
                    pend_d   = preempt;
`endif
                end else begin
                    hex1_d = seg7(own_data[7:4]);
                    hex0_d = seg7(own_data[3:0]);
                end
            end
            S_IDLE, S_GAP: begin
                grant_d  = '0;
                active_d = 1'b0;
                state_d  = S_IDLE;
`ifdef HEXARB_PREEMPT_EN
                pend_d   = 1'b0;
`endif
                if (win_found) begin
                    state_d  = S_OWN;
                    grant_d  = win_onehot;
                    owner_d  = win_idx;
                    active_d = 1'b1;
                    cnt_d    = HOLD_RELOAD;
                end
            end
            default: begin
                state_d  = S_IDLE;
                grant_d  = '0;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            owner_q  <= 3'(NUM_REQ - 1);
            active_q <= 1'b0;
            cnt_q    <= '0;
            hex0_q   <= BLANK;
            hex1_q   <= BLANK;
`ifdef HEXARB_PREEMPT_EN
            pend_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            hex0_q   <= hex0_d;
            hex1_q   <= hex1_d;
`ifdef HEXARB_PREEMPT_EN
            pend_q   <= pend_d;
`endif
        end
    end

    assign grant  = grant_q;
    assign owner  = owner_q;
    assign active = active_q;
    assign hex0   = hex0_q;
    assign hex1   = hex1_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Bench for hex_display_arbiter: directed scenarios plus random traffic
// compared against an owner/age reference model.
module tb_hex_display_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*8-1:0] data;
    logic [N-1:0]   grant;
    logic [2:0]     owner;
    logic           active;
    logic [6:0]     hex0, hex1;

    int total = 0;
    int bad   = 0;

    hex_display_arbiter #(
        .NUM_REQ(N), .HOLD_CYCLES(HOLD), .CNT_W(26)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .data(data),
        .grant(grant), .owner(owner), .active(active),
        .hex0(hex0), .hex1(hex1)
    );

    always #5 clk = ~clk;

    logic [6:0] seg [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Reference: who holds the display (-1 none), how long, and whether
    // the previous cycle ended an ownership.
    int         m_own  = -1;
    int         m_last = N - 1;
    int         m_age  = 0;
    bit         m_gap  = 0;
    bit         m_pre  = 0;
    logic [6:0] m_h0   = 7'h7F;
    logic [6:0] m_h1   = 7'h7F;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int scan(input int last, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [7:0] b;
        bit rel;
        int p;
        m_h0 = 7'h7F;
        m_h1 = 7'h7F;
        if (reset) begin
            m_own = -1; m_gap = 0; m_last = N - 1;
            m_age = 0;  m_pre = 0;
        end else if (m_own < 0) begin
            p = scan(m_last, req);
`ifdef HEXARB_PREEMPT_EN
            if (m_gap && m_pre && req[0]) p = 0;
`endif
            m_pre = 0;
            m_gap = 0;
            if (p >= 0) begin
                m_own = p; m_last = p; m_age = 1;
            end
        end else begin
            rel = !req[m_own]
               || (m_age >= HOLD && (req & ~(N'(1) << m_own)) != 0);
`ifdef HEXARB_PREEMPT_EN
            if (m_own != 0 && req[0]) begin
                rel = 1; m_pre = 1;
            end
`endif
            if (rel) begin
                m_own = -1; m_gap = 1;
            end else begin
                if (m_age < HOLD) m_age++;
                b = 8'(data >> (8 * m_own));
                m_h1 = seg[b[7:4]];
                m_h0 = seg[b[3:0]];
            end
        end
    endtask

    task automatic tick(input string tag);
        logic [N-1:0] eg;
        @(posedge clk);
        model_step();
        #1;
        eg = (m_own >= 0) ? (N'(1) << m_own) : '0;
        check({tag, ".grant"},  32'(grant),  32'(eg));
        check({tag, ".owner"},  32'(owner),  32'(m_last));
        check({tag, ".active"}, 32'(active), 32'(m_own >= 0));
        check({tag, ".hex0"},   32'(hex0),   32'(m_h0));
        check({tag, ".hex1"},   32'(hex1),   32'(m_h1));
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        data  = '0;
        run("reset", 3);
        reset = 1'b0;
        run("idle", 10);

        data  = 32'h003A_0000;
        req   = 4'b0100;
        run("single", 12);
        req   = 4'b0000;
        run("single_rel", 4);

        data  = 32'h8877_6655;
        req   = 4'b1011;
        run("rotate", 30);
        req   = 4'b0000;
        run("rot_rel", 3);

        req   = 4'b0010;
        run("early_a", 3);
        req   = 4'b1010;
        tick("early_b");
        req   = 4'b1000;
        run("early_c", 6);

        req   = 4'b1111;
        run("midrst_a", 3);
        reset = 1'b1;
        tick("midrst_b");
        reset = 1'b0;
        run("midrst_c", 8);

        req   = 4'b0000;
        run("pre_idle", 3);
        req   = 4'b0100;
        run("pre_a", 3);
        req   = 4'b0101;
        run("pre_b", 8);

        for (int i = 0; i < 2000; i++) begin
            data = $urandom;
            if ($urandom_range(7, 0) == 0) req = N'($urandom);
            reset = ($urandom_range(199, 0) == 0);
            tick("random");
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
